// File: rtl/atm_pkg.sv
// Shared constants, op codes and reset contents for the ATM account engine.
// Op codes share one encoding with the controller's session states.
package atm_pkg;

  localparam int NUM_ACCOUNTS = 10;
  localparam int PIN_W        = 16;
  localparam int BAL_W        = 32;
  localparam int IDX_W        = 4;
  localparam int OP_W         = 3;

  typedef enum logic [OP_W-1:0] {
    WAITING        = 3'd0,
    AUTHENTICATION = 3'd1,
    MENU           = 3'd2,
    BALANCE        = 3'd3,
    WITHDRAW       = 3'd4,
    DEPOSIT        = 3'd5,
    CHANGE_PIN     = 3'd6
  } op_e;

  function automatic logic [BAL_W-1:0] reset_bal(input int unsigned i);
    return BAL_W'(1000 * (i + 1));
  endfunction

  function automatic logic [PIN_W-1:0] reset_pin(input int unsigned i);
    return PIN_W'(1000 + i);
  endfunction

endpackage

// File: rtl/atm_functions_if.sv
// Request/result bundle between the session controller and the
// account engine.
interface atm_functions_if;
  import atm_pkg::*;

  logic [IDX_W-1:0] acc_num;
  logic [PIN_W-1:0] pin;
  logic [PIN_W-1:0] new_pin;
  logic [BAL_W-1:0] amount;
  logic [OP_W-1:0]  op;
  logic             op_valid;
  logic [IDX_W-1:0] acc_index;
  logic             acc_found;
  logic             acc_auth;
  logic [BAL_W-1:0] balance;
  logic             success;
  logic             done;

  modport master (
    output acc_num, pin, new_pin, amount, op, op_valid,
    input  acc_index, acc_found, acc_auth, balance, success, done
  );

  modport slave (
    input  acc_num, pin, new_pin, amount, op, op_valid,
    output acc_index, acc_found, acc_auth, balance, success, done
  );

endinterface

// File: rtl/atm_functions_authenticator.sv
// Combinational account lookup and PIN match against the live PIN table.
// Unknown accounts alias index 0 but can never authenticate.
module authenticator
  import atm_pkg::*;
(
  input  logic [IDX_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] pins [NUM_ACCOUNTS],
  output logic [IDX_W-1:0] acc_index,
  output logic             acc_found,
  output logic             acc_auth
);

  always_comb begin
    acc_found = acc_num < IDX_W'(NUM_ACCOUNTS);
    acc_index = acc_found ? acc_num : '0;
    acc_auth  = acc_found && (pin == pins[acc_index]);
  end

endmodule

// File: rtl/atm_functions.sv
// Account database and single-cycle transaction engine.
// Results are registered one cycle after the request strobe.
module atm_functions
  import atm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  atm_functions_if.slave  bus
);

  logic [PIN_W-1:0] pins [NUM_ACCOUNTS];
  logic [BAL_W-1:0] bals [NUM_ACCOUNTS];

  logic [IDX_W-1:0] idx;
  logic             found;
  logic             auth;
  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W-1:0] nxt_bal;
  logic [BAL_W:0]   sum;
  logic             bal_we;
  logic             pin_we;
  logic             ok;
  logic [BAL_W-1:0] res_bal;
  logic             res_ok;
  logic             done_q;
  op_e              op;

  authenticator u_auth (
    .acc_num   (bus.acc_num),
    .pin       (bus.pin),
    .pins      (pins),
    .acc_index (idx),
    .acc_found (found),
    .acc_auth  (auth)
  );

  assign bus.acc_index = idx;
  assign bus.acc_found = found;
  assign bus.acc_auth  = auth;
  assign bus.balance   = res_bal;
  assign bus.success   = res_ok;
  assign bus.done      = done_q;

  assign op      = op_e'(bus.op);
  assign cur_bal = bals[idx];
  assign sum     = {1'b0, cur_bal} + {1'b0, bus.amount};

  always_comb begin
    nxt_bal = cur_bal;
    bal_we  = 1'b0;
    pin_we  = 1'b0;
    ok      = 1'b0;
    if (auth) begin
      unique case (1'b1)
        op == BALANCE: ok = 1'b1;
        op == WITHDRAW: begin
          if (bus.amount <= cur_bal) begin
            nxt_bal = cur_bal - bus.amount;
            bal_we  = 1'b1;
            ok      = 1'b1;
          end
        end
        op == DEPOSIT: begin
          // carry-out means the account would wrap
          if (!sum[BAL_W]) begin
            nxt_bal = sum[BAL_W-1:0];
            bal_we  = 1'b1;
            ok      = 1'b1;
          end
        end
        op == CHANGE_PIN: begin
          pin_we = 1'b1;
          ok     = 1'b1;
        end
        default: ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bals[i] <= reset_bal(i);
        pins[i] <= reset_pin(i);
      end
      res_bal <= '0;
      res_ok  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= bus.op_valid;
      if (bus.op_valid) begin
        res_ok  <= ok;
        res_bal <= auth ? nxt_bal : '0;
        if (bal_we) bals[idx] <= nxt_bal;
        if (pin_we) pins[idx] <= bus.new_pin;
      end
    end
  end

endmodule

// File: tb/tb_atm_functions.sv
// Bench for atm_functions: directed scenarios plus randomized traffic
// checked every cycle against a behavioural account model.
module tb_atm_functions;
  import atm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  atm_functions_if bus();

  atm_functions dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  longint unsigned m_bal [10];
  int unsigned     m_pin [10];
  logic            exp_done;
  logic            exp_ok;
  logic [31:0]     exp_bal;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_bal[i] = 1000 * (i + 1);
      m_pin[i] = 1000 + i;
    end
    exp_done = 1'b0;
    exp_ok   = 1'b0;
    exp_bal  = '0;
  endtask

  task automatic model_op();
    int a;
    bit au;
    longint unsigned amt;
    a   = int'(bus.acc_num);
    amt = longint'(bus.amount);
    au  = (a < 10) && (int'(bus.pin) == m_pin[a % 10]);
    exp_ok = 1'b0;
    if (!au) begin
      exp_bal = '0;
    end else begin
      case (int'(bus.op))
        3: exp_ok = 1'b1;
        4: if (amt <= m_bal[a]) begin
             m_bal[a] -= amt;
             exp_ok = 1'b1;
           end
        5: if (m_bal[a] + amt <= 64'hFFFF_FFFF) begin
             m_bal[a] += amt;
             exp_ok = 1'b1;
           end
        6: begin
             m_pin[a] = int'(bus.new_pin);
             exp_ok = 1'b1;
           end
        default: exp_ok = 1'b0;
      endcase
      exp_bal = 32'(m_bal[a]);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      exp_done = bus.op_valid;
      if (bus.op_valid) model_op();
    end
  end

  always @(negedge clk) begin
    int a;
    bit f;
    int ei;
    a  = int'(bus.acc_num);
    f  = a < 10;
    ei = f ? a : 0;
    chk("done", bus.done, exp_done);
    chk("success", bus.success, exp_ok);
    chk("balance", bus.balance, exp_bal);
    chk("acc_found", bus.acc_found, f);
    chk("acc_index", bus.acc_index, ei);
    chk("acc_auth", bus.acc_auth, f && (int'(bus.pin) == m_pin[ei]));
  end

  task automatic set_req(input int o, input int a, input int p,
                         input int np, input logic [31:0] amt);
    bus.op      = 3'(o);
    bus.acc_num = 4'(a);
    bus.pin     = 16'(p);
    bus.new_pin = 16'(np);
    bus.amount  = amt;
  endtask

  task automatic issue(input int o, input int a, input int p,
                       input int np, input logic [31:0] amt);
    @(posedge clk);
    #1;
    set_req(o, a, p, np, amt);
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  initial begin
    int a;
    set_req(0, 0, 0, 0, 0);
    bus.op_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset balance", bus.balance, 0);
    chk("reset success", bus.success, 0);
    chk("reset done", bus.done, 0);
    #20 rst = 1'b1;

    issue(3, 2, 1002, 0, 0);
    chk("bal q done", bus.done, 1);
    chk("bal q success", bus.success, 1);
    chk("bal q balance", bus.balance, 3000);

    issue(4, 0, 1000, 0, 500);
    chk("wd500 success", bus.success, 1);
    chk("wd500 balance", bus.balance, 500);
    issue(4, 0, 1000, 0, 600);
    chk("wd600 success", bus.success, 0);
    chk("wd600 balance", bus.balance, 500);

    issue(5, 9, 1009, 0, 250);
    chk("dep250 success", bus.success, 1);
    chk("dep250 balance", bus.balance, 10250);
    issue(5, 9, 1009, 0, 32'hFFFF_FFFF);
    chk("dep ovf success", bus.success, 0);
    chk("dep ovf balance", bus.balance, 10250);

    issue(6, 4, 1004, 16'hBEEF, 0);
    chk("chpin success", bus.success, 1);
    chk("chpin balance", bus.balance, 5000);
    set_req(3, 4, 1004, 0, 0);
    #1 chk("old pin auth", bus.acc_auth, 0);
    issue(3, 4, 1004, 0, 0);
    chk("old pin success", bus.success, 0);
    chk("old pin balance", bus.balance, 0);
    set_req(3, 4, 16'hBEEF, 0, 0);
    #1 chk("new pin auth", bus.acc_auth, 1);
    issue(3, 4, 16'hBEEF, 0, 0);
    chk("new pin success", bus.success, 1);
    chk("new pin balance", bus.balance, 5000);

    set_req(4, 12, 1000, 0, 1);
    #1;
    chk("acc12 found", bus.acc_found, 0);
    chk("acc12 auth", bus.acc_auth, 0);
    chk("acc12 index", bus.acc_index, 0);
    issue(4, 12, 1000, 0, 1);
    chk("acc12 success", bus.success, 0);

    issue(2, 3, 1003, 0, 0);
    chk("bad op success", bus.success, 0);
    chk("bad op done", bus.done, 1);
    chk("bad op balance", bus.balance, 4000);

    @(posedge clk);
    #1;
    set_req(4, 1, 1001, 0, 700);
    bus.op_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("midrst balance", bus.balance, 0);
    chk("midrst success", bus.success, 0);
    chk("midrst done", bus.done, 0);
    #10;
    bus.op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst no done", bus.done, 0);
    issue(3, 1, 1001, 0, 0);
    chk("after rst balance", bus.balance, 2000);
    chk("after rst success", bus.success, 1);

    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      a = $urandom_range(0, 11);
      bus.acc_num  = 4'(a);
      bus.op_valid = $urandom_range(0, 3) != 0;
      bus.op       = 3'($urandom_range(0, 7));
      if (a < 10 && $urandom_range(0, 7) != 0)
        bus.pin = 16'(m_pin[a]);
      else
        bus.pin = 16'($urandom_range(0, 65535));
      bus.new_pin = ($urandom_range(0, 3) == 0) ? 16'(1000 + a)
                                                : 16'($urandom);
      case ($urandom_range(0, 3))
        0: bus.amount = 32'($urandom_range(0, 3000));
        1: bus.amount = 32'($urandom);
        2: bus.amount = (a < 10) ? 32'(m_bal[a]) : 32'd0;
        default: bus.amount = (a < 10) ? 32'(64'hFFFF_FFFF - m_bal[a])
                                       : 32'd1;
      endcase
    end
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
